alu_share_ctrl: RTL and testbench
=================================

# alu_share_ctrl

Two-requester controller that shares the single combinational ALU between independent clients. It arbitrates round-robin, latches the winner's operands and opcode, drives the ALU, registers the result and returns it over a valid/ready response handshake. It sits between the ALU instance and its two users, for example the main datapath and a branch/address unit.

## Interface
- WIDTH, 32, operand/result width
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid_0 / req_valid_1  in  1  requester k has an operation
- req_ready_0 / req_ready_1  out  1  controller accepts requester k this cycle
- a_0, b_0 / a_1, b_1  in  WIDTH  operands of requester k
- op_0 / op_1  in  2  ALU opcode of requester k, passed through without interpretation
- rsp_valid_0 / rsp_valid_1  out  1  result for requester k available
- rsp_ready_0 / rsp_ready_1  in  1  requester k consumes result
- rsp_data  out  WIDTH  result, shared by both requesters, qualified by rsp_valid_k
- alu_a, alu_b  out  WIDTH  to ALU operand inputs
- alu_op  out  2  to ALU opcode input
- alu_result  in  WIDTH  from ALU output, combinational function of alu_a/alu_b/alu_op
- busy  out  1  high whenever state is not IDLE

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE: grant = pointer if req_valid[pointer], else the other requester if its valid is high, else none. req_ready_k = 1 only for the granted k, combinational. On the handshake (valid & ready): latch a/b/op into operand registers, latch owner = k, set pointer = ~k, go to EXEC.
- EXEC: lasts exactly 1 cycle. alu_a/alu_b/alu_op driven from operand registers. At the clock edge, capture alu_result into the result register and go to RESP.
- RESP: rsp_valid_owner = 1, rsp_data = result register. Hold both until rsp_ready_owner = 1, then go to IDLE. rsp_valid of the non-owner stays 0.
- All req_ready = 0 in EXEC and RESP. A request held valid across those states waits and is arbitrated at the next IDLE.
- alu_a/alu_b/alu_op keep the operand registers in every state and change only on an accepted request.
- rsp_data keeps the last result until the next EXEC capture.
- Width rules: no arithmetic is performed here. The result is WIDTH bits, copied verbatim.

## Timing
- Reset (async assert, sync release): state IDLE, pointer = 0, owner = 0, operand/result registers = 0. All outputs are 0: alu_a, alu_b, alu_op, rsp_data, all rsp_valid, busy. req_ready follows the IDLE grant rule as soon as reset deasserts.
- Reset mid-transaction: the in-flight operation is discarded and no rsp_valid is issued.
- Latency: handshake edge N, ALU driven during cycle N+1, rsp_valid high from cycle N+2.
- Minimum issue interval: 3 cycles when rsp_ready is held high.
- Simultaneous requests: the pointer winner is served first. The other requester is served in the next IDLE cycle even if the first re-requests immediately.
- Single requester: always granted regardless of pointer. The pointer still toggles to the other requester.
- rsp_ready asserted before rsp_valid has no effect. rsp_ready from the non-owner is ignored.

## Test plan
- Reset, then single request: bench ALU model (00 a+b, 01 a-b, 10 a&b, 11 a|b). Req0 a=2001 b=4001 op=00 -> req_ready_0 same cycle; alu_a=2001 alu_b=4001 next cycle; rsp_valid_0 with rsp_data=6002 two cycles after the handshake.
- Collision: both valid in the same cycle after reset (req0 op=01 2001,4001; req1 op=10 0xF0F0,0x0FF0) -> req0 served first with 0xFFFFF830, then req1 with 0x000000F0. Next collision -> req1 is not favored and req0 wins (pointer flipped).
- Backpressure: hold rsp_ready_1 low for 5 cycles -> rsp_valid_1 and rsp_data stable, req_ready_0 = 0 throughout, busy = 1. Release -> IDLE next cycle.
- Fairness streak: both valid continuously for 8 ops -> grants alternate 0,1,0,1,...; each response arrives 3 cycles apart.
- Async reset during EXEC -> all outputs 0 immediately; no rsp_valid afterwards; a fresh request completes normally.
- Op passthrough: req1 with op=11, a=0x00FF0000, b=0x000000FF -> alu_op=11 during EXEC; rsp_data=0x00FF00FF; rsp_valid_0 stays 0.

Source files
------------

// File: rtl/alu_share_if.sv
// Request/response bundle between the two ALU clients and alu_share_ctrl.
// The master side is the requester pair; the slave side is the controller.
interface alu_share_if #(
    parameter int WIDTH = 32
);
    logic             req_valid_0;
    logic             req_valid_1;
    logic             req_ready_0;
    logic             req_ready_1;
    logic [WIDTH-1:0] a_0;
    logic [WIDTH-1:0] b_0;
    logic [WIDTH-1:0] a_1;
    logic [WIDTH-1:0] b_1;
    logic [1:0]       op_0;
    logic [1:0]       op_1;
    logic             rsp_valid_0;
    logic             rsp_valid_1;
    logic             rsp_ready_0;
    logic             rsp_ready_1;
    logic [WIDTH-1:0] rsp_data;

    modport master (
        output req_valid_0, req_valid_1, a_0, b_0, a_1, b_1, op_0, op_1,
        output rsp_ready_0, rsp_ready_1,
        input  req_ready_0, req_ready_1, rsp_valid_0, rsp_valid_1, rsp_data
    );

    modport slave (
        input  req_valid_0, req_valid_1, a_0, b_0, a_1, b_1, op_0, op_1,
        input  rsp_ready_0, rsp_ready_1,
        output req_ready_0, req_ready_1, rsp_valid_0, rsp_valid_1, rsp_data
    );
endinterface

// File: rtl/alu_share_ctrl.sv
// Shares one combinational ALU between two requesters. Round-robin grant in
// IDLE, one EXEC cycle driving the ALU from latched operands, then a RESP
// state holding the registered result until the owning requester takes it.
module alu_share_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_share_if.slave       bus,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_op,
    input  logic [WIDTH-1:0] alu_result,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state;
    logic             ptr;
    logic             owner;
    logic [WIDTH-1:0] a_p0;
    logic [WIDTH-1:0] b_p0;
    logic [1:0]       op_p0;
    logic [WIDTH-1:0] res_p1;

    logic             gnt_vld;
    logic             gnt_id;
    logic             rsp_take;

    // Round-robin grant: the pointer side wins, otherwise whoever is asking.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = 1'b0;
        if (state == IDLE) begin
            if (ptr ? bus.req_valid_1 : bus.req_valid_0) begin
                gnt_vld = 1'b1;
                gnt_id  = ptr;
            end else if (ptr ? bus.req_valid_0 : bus.req_valid_1) begin
                gnt_vld = 1'b1;
                gnt_id  = ~ptr;
            end
        end
    end

    assign bus.req_ready_0 = gnt_vld & ~gnt_id;
    assign bus.req_ready_1 = gnt_vld &  gnt_id;

    // Only the owner's rsp_ready can retire a response.
    assign rsp_take = owner ? bus.rsp_ready_1 : bus.rsp_ready_0;

    assign alu_a        = a_p0;
    assign alu_b        = b_p0;
    assign alu_op       = op_p0;
    assign bus.rsp_data = res_p1;

    // Controller FSM with registered operand, result, valid and busy outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            ptr             <= 1'b0;
            owner           <= 1'b0;
            a_p0            <= '0;
            b_p0            <= '0;
            op_p0           <= '0;
            res_p1          <= '0;
            bus.rsp_valid_0 <= 1'b0;
            bus.rsp_valid_1 <= 1'b0;
            busy            <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_vld) begin
                        a_p0  <= gnt_id ? bus.a_1  : bus.a_0;
                        b_p0  <= gnt_id ? bus.b_1  : bus.b_0;
                        op_p0 <= gnt_id ? bus.op_1 : bus.op_0;
                        owner <= gnt_id;
                        ptr   <= ~gnt_id;
                        busy  <= 1'b1;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    res_p1 <= alu_result;
                    if (owner) begin
                        bus.rsp_valid_1 <= 1'b1;
                    end else begin
                        bus.rsp_valid_0 <= 1'b1;
                    end
                    state <= RESP;
                end
                RESP: begin
                    if (rsp_take) begin
                        bus.rsp_valid_0 <= 1'b0;
                        bus.rsp_valid_1 <= 1'b0;
                        busy            <= 1'b0;
                        state           <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: directed scenarios followed by random traffic,
// checked against a transaction-level model (round-robin pointer + ALU ops).
module tb_alu_share_ctrl;
    localparam int WIDTH  = 32;
    localparam int PERIOD = 10;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [1:0]       alu_op;
    logic [WIDTH-1:0] alu_result;
    logic             busy;

    alu_share_if #(.WIDTH(WIDTH)) bus ();

    alu_share_ctrl #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .busy       (busy)
    );

    always #(PERIOD/2) clk = ~clk;

    // The shared ALU the controller drives.
    always_comb begin
        alu_result = alu_a | alu_b;
        case (alu_op)
            2'b00: alu_result = alu_a + alu_b;
            2'b01: alu_result = alu_a - alu_b;
            2'b10: alu_result = alu_a & alu_b;
            default: alu_result = alu_a | alu_b;
        endcase
    end

    int  total = 0;
    int  bad   = 0;
    int  m_ptr = 0;
    time t_rsp = 0;
    time t_prev = 0;

    function automatic logic [31:0] alu_ref(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            2'b00: return a + b;
            2'b01: return a - b;
            2'b10: return a & b;
            default: return a | b;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs_zero(input string tag);
        chk({tag, "_alu_a"}, alu_a, 0);
        chk({tag, "_alu_b"}, alu_b, 0);
        chk({tag, "_alu_op"}, {30'd0, alu_op}, 0);
        chk({tag, "_rsp_data"}, bus.rsp_data, 0);
        chk({tag, "_rsp_valid_0"}, {31'd0, bus.rsp_valid_0}, 0);
        chk({tag, "_rsp_valid_1"}, {31'd0, bus.rsp_valid_1}, 0);
        chk({tag, "_busy"}, {31'd0, busy}, 0);
    endtask

    task automatic do_reset();
        bus.req_valid_0 = 0; bus.req_valid_1 = 0;
        bus.rsp_ready_0 = 0; bus.rsp_ready_1 = 0;
        @(negedge clk);
        rst_n = 0;
        @(posedge clk); #1;
        chk_idle_outputs_zero("reset");
        @(negedge clk);
        rst_n = 1;
        m_ptr = 0;
    endtask

    task automatic set_rsp_ready(input int k, input logic v);
        if (k == 0) bus.rsp_ready_0 = v; else bus.rsp_ready_1 = v;
    endtask

    // One complete transaction: arbitration, EXEC, RESP (with rdelay cycles of
    // owner backpressure), retire. Loser's request is left pending.
    task automatic txn(input bit v0, input bit v1, input int rdelay, input bit keep,
                       output int who, output logic [31:0] data);
        int          w;
        logic [31:0] ea, eb, exp;
        logic [1:0]  eop;
        logic        saved;
        bit          pend[2];
        pend[0] = v0;
        pend[1] = v1;
        w = pend[m_ptr] ? m_ptr : 1 - m_ptr;
        bus.req_valid_0 = v0;
        bus.req_valid_1 = v1;
        bus.rsp_ready_0 = 0;
        bus.rsp_ready_1 = 0;
        #1;
        chk("req_ready_0", {31'd0, bus.req_ready_0}, {31'd0, w == 0});
        chk("req_ready_1", {31'd0, bus.req_ready_1}, {31'd0, w == 1});
        chk("busy_idle", {31'd0, busy}, 0);
        ea  = (w == 1) ? bus.a_1  : bus.a_0;
        eb  = (w == 1) ? bus.b_1  : bus.b_0;
        eop = (w == 1) ? bus.op_1 : bus.op_0;
        exp = alu_ref(eop, ea, eb);
        @(posedge clk); #1;
        m_ptr = 1 - w;
        if (!keep) begin
            if (w == 0) bus.req_valid_0 = 0; else bus.req_valid_1 = 0;
        end
        // Early rsp_ready (before rsp_valid) must not retire anything.
        bus.rsp_ready_0 = (rdelay == 0);
        bus.rsp_ready_1 = (rdelay == 0);
        #1;
        chk("exec_alu_a", alu_a, ea);
        chk("exec_alu_b", alu_b, eb);
        chk("exec_alu_op", {30'd0, alu_op}, {30'd0, eop});
        chk("exec_busy", {31'd0, busy}, 1);
        chk("exec_req_ready_0", {31'd0, bus.req_ready_0}, 0);
        chk("exec_req_ready_1", {31'd0, bus.req_ready_1}, 0);
        chk("exec_rsp_valid_0", {31'd0, bus.rsp_valid_0}, 0);
        chk("exec_rsp_valid_1", {31'd0, bus.rsp_valid_1}, 0);
        @(posedge clk); #1;
        chk("rsp_valid_own", {31'd0, (w == 1) ? bus.rsp_valid_1 : bus.rsp_valid_0}, 1);
        chk("rsp_valid_other", {31'd0, (w == 1) ? bus.rsp_valid_0 : bus.rsp_valid_1}, 0);
        chk("rsp_data", bus.rsp_data, exp);
        data   = bus.rsp_data;
        t_prev = t_rsp;
        t_rsp  = $time;
        if (rdelay > 0) begin
            saved = (w == 1) ? bus.req_valid_0 : bus.req_valid_1;
            if (w == 1) bus.req_valid_0 = 1; else bus.req_valid_1 = 1;
            set_rsp_ready(1 - w, 1);
            for (int i = 0; i < rdelay; i++) begin
                @(posedge clk); #1;
                chk("hold_rsp_valid_own", {31'd0, (w == 1) ? bus.rsp_valid_1 : bus.rsp_valid_0}, 1);
                chk("hold_rsp_valid_other", {31'd0, (w == 1) ? bus.rsp_valid_0 : bus.rsp_valid_1}, 0);
                chk("hold_rsp_data", bus.rsp_data, exp);
                chk("hold_req_ready_0", {31'd0, bus.req_ready_0}, 0);
                chk("hold_req_ready_1", {31'd0, bus.req_ready_1}, 0);
                chk("hold_busy", {31'd0, busy}, 1);
            end
            if (w == 1) bus.req_valid_0 = saved; else bus.req_valid_1 = saved;
            set_rsp_ready(1 - w, 0);
            set_rsp_ready(w, 1);
        end
        @(posedge clk); #1;
        bus.rsp_ready_0 = 0;
        bus.rsp_ready_1 = 0;
        chk("done_rsp_valid_0", {31'd0, bus.rsp_valid_0}, 0);
        chk("done_rsp_valid_1", {31'd0, bus.rsp_valid_1}, 0);
        chk("done_busy", {31'd0, busy}, 0);
        chk("done_rsp_data_kept", bus.rsp_data, exp);
        who = w;
    endtask

    initial begin
        int          who;
        int          prev_who;
        logic [31:0] d;
        bit          rv0, rv1;
        int          sel;

        bus.req_valid_0 = 0; bus.req_valid_1 = 0;
        bus.rsp_ready_0 = 0; bus.rsp_ready_1 = 0;
        bus.a_0 = 0; bus.b_0 = 0; bus.op_0 = 0;
        bus.a_1 = 0; bus.b_1 = 0; bus.op_1 = 0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk_idle_outputs_zero("por");
        chk("por_req_ready_0", {31'd0, bus.req_ready_0}, 0);
        @(negedge clk);
        rst_n = 1;

        // Single request on requester 0
        bus.a_0 = 2001; bus.b_0 = 4001; bus.op_0 = 2'b00;
        txn(1, 0, 0, 0, who, d);
        chk("single_who", who, 0);
        chk("single_data", d, 32'd6002);

        // Collision after reset: req0 first, then req1, then pointer favours req0
        do_reset();
        bus.a_0 = 2001;     bus.b_0 = 4001;     bus.op_0 = 2'b01;
        bus.a_1 = 'hF0F0;   bus.b_1 = 'h0FF0;   bus.op_1 = 2'b10;
        txn(1, 1, 0, 0, who, d);
        chk("coll_who_first", who, 0);
        chk("coll_data_first", d, 32'hFFFFF830);
        txn(0, 1, 0, 0, who, d);
        chk("coll_who_second", who, 1);
        chk("coll_data_second", d, 32'h000000F0);
        txn(1, 1, 0, 0, who, d);
        chk("coll2_who", who, 0);
        txn(0, 1, 0, 0, who, d);
        chk("coll2_who_second", who, 1);

        // Backpressure on requester 1 for 5 cycles
        bus.a_1 = 'h1234_0000; bus.b_1 = 'h0000_5678; bus.op_1 = 2'b11;
        txn(0, 1, 5, 0, who, d);
        chk("bp_who", who, 1);
        chk("bp_data", d, 32'h1234_5678);

        // Fairness streak: both requesting continuously
        prev_who = 1;
        for (int i = 0; i < 8; i++) begin
            bus.a_0 = $urandom; bus.b_0 = $urandom; bus.op_0 = 2'($urandom);
            bus.a_1 = $urandom; bus.b_1 = $urandom; bus.op_1 = 2'($urandom);
            txn(1, 1, 0, 1, who, d);
            chk("streak_alternate", who, 1 - prev_who);
            if (i > 0) chk("streak_interval", 32'(t_rsp - t_prev), 3 * PERIOD);
            prev_who = who;
        end
        bus.req_valid_0 = 0;
        bus.req_valid_1 = 0;

        // Opcode passthrough on requester 1
        bus.a_1 = 'h00FF0000; bus.b_1 = 'h000000FF; bus.op_1 = 2'b11;
        txn(0, 1, 1, 0, who, d);
        chk("pass_who", who, 1);
        chk("pass_data", d, 32'h00FF00FF);
        chk("pass_alu_op_hold", {30'd0, alu_op}, 3);

        // Asynchronous reset while EXEC is in progress
        bus.a_0 = 'hDEAD_BEEF; bus.b_0 = 'h0000_0011; bus.op_0 = 2'b00;
        bus.req_valid_0 = 1;
        #1;
        @(posedge clk); #1;
        bus.req_valid_0 = 0;
        chk("mid_busy_before", {31'd0, busy}, 1);
        #1;
        rst_n = 0;
        #1;
        chk_idle_outputs_zero("mid_reset");
        @(negedge clk);
        rst_n = 1;
        m_ptr = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("post_reset_rsp_valid_0", {31'd0, bus.rsp_valid_0}, 0);
            chk("post_reset_busy", {31'd0, busy}, 0);
        end
        bus.a_0 = 'h0000_0100; bus.b_0 = 'h0000_0001; bus.op_0 = 2'b01;
        txn(1, 0, 0, 0, who, d);
        chk("fresh_data", d, 32'h0000_00FF);

        // Random traffic against the model
        for (int i = 0; i < 40; i++) begin
            bus.a_0 = $urandom; bus.b_0 = $urandom; bus.op_0 = 2'($urandom);
            bus.a_1 = $urandom; bus.b_1 = $urandom; bus.op_1 = 2'($urandom);
            sel = $urandom_range(1, 3);
            rv0 = sel[0];
            rv1 = sel[1];
            txn(rv0, rv1, $urandom_range(0, 2), 0, who, d);
        end
        bus.req_valid_0 = 0;
        bus.req_valid_1 = 0;
        @(posedge clk); #1;
        chk("final_busy", {31'd0, busy}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
